trap_csr_unit: RTL and testbench
================================

# trap_csr_unit

Machine-mode trap and CSR state block for the pipelined core; the consumer of the exception/cause/mret/privilege-enable signals produced by the pipeline's exception detection stage. On a trap it saves state (mepc, mcause, mtval, mstatus), switches to M-mode and redirects fetch to mtvec. On `mret` it restores privilege and redirects to mepc. It also serves Zicsr reads and writes for the trap CSRs and feeds the current privilege mode back to the detection stage.

## Interface
Parameters:
- `FLUSH_CYCLES`, 2, cycles `o_flush` is held after a trap or mret (legal range ≥ 1).
- `RESET_MTVEC`, 32'h0000_1000, mtvec reset value (bits [1:0] must be 0).

Ports (one clock; reset is asynchronous and active-low):
- `i_clk` in 1: clock, rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_privEnable` in 1: qualifies `i_exception`/`i_mret`; neither has any effect while 0.
- `i_exception` in 1: trap request from the exception stage.
- `i_cause` in 4: exception code (0 inst-misaligned, 1 inst-access-fault, 2 illegal, 3 breakpoint, 8/9/11 ecall from U/S/M).
- `i_mret` in 1: mret retiring.
- `i_PC` in 32: PC of the faulting or mret instruction.
- `i_inst` in 32: instruction word of the faulting instruction.
- `i_csrAddr` in 12: CSR address.
- `i_csrOp` in 2: 00 none, 01 write, 10 set, 11 clear.
- `i_csrWdata` in 32: CSR write operand.
- `o_csrRdata` out 32: combinational read of `i_csrAddr`.
- `o_nowPrivMode` out 2: current privilege (00 U, 11 M).
- `o_redirect` out 1: one-cycle fetch redirect pulse.
- `o_redirectPC` out 32: redirect target, valid while `o_redirect`=1.
- `o_flush` out 1: squash younger pipeline stages.

## Operation
- CSR map:
  - mstatus 0x300: only MIE[3], MPIE[7], MPP[12:11] are implemented; other bits read 0.
  - mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343.
  - Unmapped addresses read 0 and ignore writes.
- WARL rules:
  - mtvec[1:0] and mepc[1:0] are forced to 0 on write.
  - An MPP write of 01 or 10 stores 00.
  - mcause is stored as {28'b0, cause}; the interrupt bit is always 0.
- FSM states IDLE and FLUSH, with a down-counter of width clog2(FLUSH_CYCLES)+1.
- Trap accepted in IDLE when `i_privEnable & i_exception`:
  - mepc ← {i_PC[31:2], 2'b00}.
  - mcause ← i_cause.
  - mtval ← i_PC for cause 0/1, i_inst for cause 2, otherwise 0.
  - MPP ← priv; MPIE ← MIE; MIE ← 0; priv ← 11.
  - Redirect target = mtvec (direct mode only).
- mret accepted in IDLE when `i_privEnable & i_mret & ~i_exception`:
  - priv ← MPP; MIE ← MPIE; MPIE ← 1; MPP ← 00.
  - Redirect target = mepc.
- Priority:
  - Exception over mret.
  - Trap/mret over a same-cycle CSR write; the CSR write is dropped because it belongs to the squashed instruction.
- CSR write is performed in IDLE when `i_csrOp`≠00 and no trap/mret is accepted. Set/clear use the current register value.
- In FLUSH, all inputs except CSR reads are ignored: no trap, mret or CSR write. The counter decrements each cycle; FLUSH → IDLE when it reaches 0.
- Reset values:
  - priv = 11.
  - mstatus = 0.
  - mtvec = RESET_MTVEC.
  - mepc, mcause, mtval, mscratch = 0.
  - FSM = IDLE.
  - `o_redirect` = 0, `o_redirectPC` = 0, `o_flush` = 0.
- Reset asserted mid-FLUSH returns to IDLE immediately, with all outputs at reset values.

## Timing
- Event sampled at rising edge N. Then from cycle N+1:
  - `o_redirect`=1 with `o_redirectPC` registered, for exactly 1 cycle.
  - `o_flush`=1 for exactly FLUSH_CYCLES cycles (N+1 … N+FLUSH_CYCLES).
- CSR state and `o_nowPrivMode` update at edge N and are visible from N+1.
- The first cycle able to accept a new event is N+FLUSH_CYCLES+1.
- `o_csrRdata` is combinational, zero latency; a read in the same cycle as a write returns the old value.
- Back-to-back events: an event arriving during FLUSH is lost (by design; it is a squashed instruction).

## Test plan
- Reset → priv=11, mtvec=0x1000, all other CSRs 0, outputs 0; reset asserted mid-FLUSH → outputs 0 immediately.
- From U-mode, ecall (cause 8, PC 0x2004) → next cycle `o_redirect`=1, `o_redirectPC`=0x1000; mepc=0x2004, mcause=8, MPP=00, priv=11; `o_flush` high 2 cycles.
- Misaligned PC 0x2006 with cause 0 → mtval=0x2006, mepc=0x2004. Illegal instruction 0xFFFFFFFF with cause 2 → mtval=0xFFFFFFFF.
- Write mepc=0x3000, set mstatus MPP=00 and MPIE=1, then mret → `o_redirectPC`=0x3000, priv=00, MIE=1, MPIE=1.
- Exception and mret in the same cycle → trap taken, target=mtvec. CSR write to mscratch in a trap cycle → mscratch unchanged. Event during FLUSH → ignored, no second redirect.
- CSR WARL checks:
  - Write mtvec 0x1237 → reads 0x1234.
  - Write mstatus 0xFFFF_FFFF → reads 0x0000_1888.
  - Write MPP=01 → reads 00.
  - Clear op on mscratch 0xFF with operand 0x0F → 0xF0.
  - Read 0x7C0 → 0.

Source files
------------

// File: rtl/trap_csr_unit_if.sv
// Signal bundle between the exception-detection stage and the trap/CSR unit.
// The master drives trap/mret/CSR requests; the slave returns redirect, flush and read data.
interface trap_csr_unit_if;
    logic        i_privEnable;
    logic        i_exception;
    logic [3:0]  i_cause;
    logic        i_mret;
    logic [31:0] i_PC;
    logic [31:0] i_inst;
    logic [11:0] i_csrAddr;
    logic [1:0]  i_csrOp;
    logic [31:0] i_csrWdata;
    logic [31:0] o_csrRdata;
    logic [1:0]  o_nowPrivMode;
    logic        o_redirect;
    logic [31:0] o_redirectPC;
    logic        o_flush;

    modport master (
        output i_privEnable, i_exception, i_cause, i_mret, i_PC, i_inst,
               i_csrAddr, i_csrOp, i_csrWdata,
        input  o_csrRdata, o_nowPrivMode, o_redirect, o_redirectPC, o_flush
    );

    modport slave (
        input  i_privEnable, i_exception, i_cause, i_mret, i_PC, i_inst,
               i_csrAddr, i_csrOp, i_csrWdata,
        output o_csrRdata, o_nowPrivMode, o_redirect, o_redirectPC, o_flush
    );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine-mode trap entry/exit and trap CSR file. Takes traps and mret, redirects
// fetch, holds flush for FLUSH_CYCLES, and serves Zicsr accesses to the trap CSRs.
module trap_csr_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_1000
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    trap_csr_unit_if.slave bus
);
    localparam int            CW       = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;

    typedef enum logic {IDLE, FLUSH} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    priv_q, mpp_q;
    logic          mie_q, mpie_q;
    logic [31:0]   mtvec_q, mscratch_q, mepc_q, mtval_q;
    logic [3:0]    mcause_q;
    logic          redirect_q, flush_q;
    logic [31:0]   redirect_pc_q;

    logic [31:0] mstatus, rdata, wval_d, mtval_d;
    logic [1:0]  mpp_d;
    logic        trap_acc, mret_acc, csr_we;

    assign mstatus = {19'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

    always_comb begin
        rdata = 32'b0;
        case (bus.i_csrAddr)
            A_MSTATUS:  rdata = mstatus;
            A_MTVEC:    rdata = mtvec_q;
            A_MSCRATCH: rdata = mscratch_q;
            A_MEPC:     rdata = mepc_q;
            A_MCAUSE:   rdata = {28'b0, mcause_q};
            A_MTVAL:    rdata = mtval_q;
            default:    rdata = 32'b0;
        endcase
    end

    // Set/clear operate on the value currently visible at the read port.
    always_comb begin
        wval_d = rdata;
        case (bus.i_csrOp)
            2'b01:   wval_d = bus.i_csrWdata;
            2'b10:   wval_d = rdata | bus.i_csrWdata;
            2'b11:   wval_d = rdata & ~bus.i_csrWdata;
            default: wval_d = rdata;
        endcase
    end

    always_comb begin
        mtval_d = 32'b0;
        case (bus.i_cause)
            4'd0, 4'd1: mtval_d = bus.i_PC;
            4'd2:       mtval_d = bus.i_inst;
            default:    mtval_d = 32'b0;
        endcase
    end

    // Only U and M exist, so reserved MPP encodings collapse to U.
    assign mpp_d = (wval_d[12:11] == 2'b11) ? 2'b11 : 2'b00;

    assign trap_acc = (state_q == IDLE) & bus.i_privEnable & bus.i_exception;
    assign mret_acc = (state_q == IDLE) & bus.i_privEnable & bus.i_mret & ~bus.i_exception;
    assign csr_we   = (state_q == IDLE) & ~trap_acc & ~mret_acc & (bus.i_csrOp != 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            priv_q        <= 2'b11;
            mpp_q         <= 2'b00;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mtvec_q       <= RESET_MTVEC;
            mscratch_q    <= 32'b0;
            mepc_q        <= 32'b0;
            mcause_q      <= 4'b0;
            mtval_q       <= 32'b0;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'b0;
        end else begin
            redirect_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (trap_acc) begin
                        mepc_q        <= {bus.i_PC[31:2], 2'b00};
                        mcause_q      <= bus.i_cause;
                        mtval_q       <= mtval_d;
                        mpp_q         <= priv_q;
                        mpie_q        <= mie_q;
                        mie_q         <= 1'b0;
                        priv_q        <= 2'b11;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= mtvec_q;
                        flush_q       <= 1'b1;
                        cnt_q         <= CNT_INIT;
                        state_q       <= FLUSH;
                    end else if (mret_acc) begin
                        priv_q        <= mpp_q;
                        mie_q         <= mpie_q;
                        mpie_q        <= 1'b1;
                        mpp_q         <= 2'b00;
                        redirect_q    <= 1'b1;
                        redirect_pc_q <= mepc_q;
                        flush_q       <= 1'b1;
                        cnt_q         <= CNT_INIT;
                        state_q       <= FLUSH;
                    end else if (csr_we) begin
                        case (bus.i_csrAddr)
                            A_MSTATUS: begin
                                mie_q  <= wval_d[3];
                                mpie_q <= wval_d[7];
                                mpp_q  <= mpp_d;
                            end
                            A_MTVEC:    mtvec_q    <= {wval_d[31:2], 2'b00};
                            A_MSCRATCH: mscratch_q <= wval_d;
                            A_MEPC:     mepc_q     <= {wval_d[31:2], 2'b00};
                            A_MCAUSE:   mcause_q   <= wval_d[3:0];
                            A_MTVAL:    mtval_q    <= wval_d;
                            default: ;
                        endcase
                    end
                end
                FLUSH: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_csrRdata    = rdata;
    assign bus.o_nowPrivMode = priv_q;
    assign bus.o_redirect    = redirect_q;
    assign bus.o_redirectPC  = redirect_pc_q;
    assign bus.o_flush       = flush_q;
endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit: an edge-indexed reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_trap_csr_unit;
    localparam int F = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    bit   chk_en      = 1'b0;

    trap_csr_unit_if bus();

    trap_csr_unit #(.FLUSH_CYCLES(F), .RESET_MTVEC(32'h0000_1000)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: CSRs in an address-keyed map, event timing tracked by edge index.
    logic [31:0] m [int];
    logic [1:0]  m_priv;
    int          e, last_e;
    logic [31:0] m_rpc;

    function automatic logic [31:0] mread(input logic [11:0] a);
        return m.exists(int'(a)) ? m[int'(a)] : 32'h0;
    endfunction

    function automatic logic [31:0] warl(input logic [11:0] a, input logic [31:0] v);
        logic [31:0] r;
        r = v;
        case (a)
            12'h300: begin
                r = v & 32'h0000_1888;
                if (r[12:11] == 2'b01 || r[12:11] == 2'b10) r[12:11] = 2'b00;
            end
            12'h305, 12'h341: r = v & ~32'h3;
            12'h342: r = v & 32'hF;
            default: r = v;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m.delete();
        m[12'h300] = 32'h0;
        m[12'h305] = 32'h0000_1000;
        m[12'h340] = 32'h0;
        m[12'h341] = 32'h0;
        m[12'h342] = 32'h0;
        m[12'h343] = 32'h0;
        m_priv = 2'b11;
        m_rpc  = 32'h0;
        e      = 0;
        last_e = -1000;
    endtask

    initial begin
        logic [31:0] v, old, nv;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                e = e + 1;
                if (e >= last_e + F + 1) begin
                    if (bus.i_privEnable && bus.i_exception) begin
                        v = m[12'h300];
                        m[12'h341] = bus.i_PC & ~32'h3;
                        m[12'h342] = {28'h0, bus.i_cause};
                        m[12'h343] = (bus.i_cause <= 4'd1) ? bus.i_PC :
                                     (bus.i_cause == 4'd2) ? bus.i_inst : 32'h0;
                        m[12'h300] = (32'(m_priv) << 11) | (32'(v[3]) << 7);
                        m_priv = 2'b11;
                        m_rpc  = m[12'h305];
                        last_e = e;
                    end else if (bus.i_privEnable && bus.i_mret) begin
                        v = m[12'h300];
                        m_priv = v[12:11];
                        m[12'h300] = 32'h80 | (32'(v[7]) << 3);
                        m_rpc  = m[12'h341];
                        last_e = e;
                    end else if (bus.i_csrOp != 2'b00 && m.exists(int'(bus.i_csrAddr))) begin
                        old = m[int'(bus.i_csrAddr)];
                        case (bus.i_csrOp)
                            2'b01:   nv = bus.i_csrWdata;
                            2'b10:   nv = old | bus.i_csrWdata;
                            default: nv = old & ~bus.i_csrWdata;
                        endcase
                        m[int'(bus.i_csrAddr)] = warl(bus.i_csrAddr, nv);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("mdl_rdata", bus.o_csrRdata, mread(bus.i_csrAddr));
            check("mdl_priv", 32'(bus.o_nowPrivMode), 32'(m_priv));
            check("mdl_redirect", 32'(bus.o_redirect), 32'(e == last_e));
            check("mdl_flush", 32'(bus.o_flush), 32'(e >= last_e && e < last_e + F));
            if (e == last_e) check("mdl_redirectPC", bus.o_redirectPC, m_rpc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        bus.i_privEnable = 1'b0;
        bus.i_exception  = 1'b0;
        bus.i_cause      = 4'h0;
        bus.i_mret       = 1'b0;
        bus.i_PC         = 32'h0;
        bus.i_inst       = 32'h0;
        bus.i_csrAddr    = 12'h0;
        bus.i_csrOp      = 2'b00;
        bus.i_csrWdata   = 32'h0;
    endtask

    task automatic ev(input bit exc, input bit mret, input logic [3:0] cause,
                      input logic [31:0] pc, input logic [31:0] inst);
        bus.i_privEnable = 1'b1;
        bus.i_exception  = exc;
        bus.i_mret       = mret;
        bus.i_cause      = cause;
        bus.i_PC         = pc;
        bus.i_inst       = inst;
        tick();
        idle_in();
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
        bus.i_csrAddr  = a;
        bus.i_csrOp    = op;
        bus.i_csrWdata = d;
        tick();
        bus.i_csrOp    = 2'b00;
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        bus.i_csrAddr = a;
        #1;
        check(name, bus.o_csrRdata, exp);
    endtask

    initial begin
        idle_in();
        repeat (3) tick();
        check("rst_priv", 32'(bus.o_nowPrivMode), 32'h3);
        check("rst_redirect", 32'(bus.o_redirect), 32'h0);
        check("rst_flush", 32'(bus.o_flush), 32'h0);
        rd("rst_mtvec", 12'h305, 32'h0000_1000);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mepc", 12'h341, 32'h0);
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick();

        // drop to U-mode with mret (MPP resets to U)
        ev(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        check("mret0_redirect", 32'(bus.o_redirect), 32'h1);
        check("mret0_priv", 32'(bus.o_nowPrivMode), 32'h0);
        repeat (F) tick();

        // ecall from U
        ev(1'b1, 1'b0, 4'd8, 32'h2004, 32'h0);
        check("ecall_redirect", 32'(bus.o_redirect), 32'h1);
        check("ecall_target", bus.o_redirectPC, 32'h0000_1000);
        check("ecall_priv", 32'(bus.o_nowPrivMode), 32'h3);
        rd("ecall_mepc", 12'h341, 32'h2004);
        rd("ecall_mcause", 12'h342, 32'h8);
        tick();
        check("ecall_flush2", 32'(bus.o_flush), 32'h1);
        check("ecall_nored", 32'(bus.o_redirect), 32'h0);
        tick();
        check("ecall_flush_end", 32'(bus.o_flush), 32'h0);
        rd("ecall_mpp_u", 12'h300, 32'h0);

        ev(1'b1, 1'b0, 4'd0, 32'h2006, 32'h0);
        rd("misal_mtval", 12'h343, 32'h2006);
        rd("misal_mepc", 12'h341, 32'h2004);
        repeat (F) tick();

        ev(1'b1, 1'b0, 4'd2, 32'h2010, 32'hFFFF_FFFF);
        rd("illeg_mtval", 12'h343, 32'hFFFF_FFFF);
        rd("illeg_mstatus", 12'h300, 32'h1800);
        repeat (F) tick();

        // mret to a software-written mepc
        csr_wr(12'h341, 2'b01, 32'h3000);
        csr_wr(12'h300, 2'b01, 32'h80);
        rd("pre_mret_mstatus", 12'h300, 32'h80);
        ev(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        check("mret_target", bus.o_redirectPC, 32'h3000);
        check("mret_priv", 32'(bus.o_nowPrivMode), 32'h0);
        rd("mret_mstatus", 12'h300, 32'h88);
        repeat (F) tick();

        // exception + mret + CSR write in one cycle, then an event during flush
        bus.i_csrAddr  = 12'h340;
        bus.i_csrOp    = 2'b01;
        bus.i_csrWdata = 32'h55;
        ev(1'b1, 1'b1, 4'd11, 32'h4000, 32'h0);
        check("prio_target", bus.o_redirectPC, 32'h0000_1000);
        check("prio_priv", 32'(bus.o_nowPrivMode), 32'h3);
        ev(1'b1, 1'b0, 4'd3, 32'h4100, 32'h0);
        check("inflush_nored", 32'(bus.o_redirect), 32'h0);
        rd("inflush_mcause", 12'h342, 32'hB);
        rd("prio_mscratch", 12'h340, 32'h0);
        tick();

        // WARL behaviour
        csr_wr(12'h305, 2'b01, 32'h1237);
        rd("warl_mtvec", 12'h305, 32'h1234);
        csr_wr(12'h300, 2'b01, 32'hFFFF_FFFF);
        rd("warl_mstatus", 12'h300, 32'h1888);
        csr_wr(12'h300, 2'b01, 32'h800);
        rd("warl_mpp01", 12'h300, 32'h0);
        csr_wr(12'h340, 2'b01, 32'hFF);
        csr_wr(12'h340, 2'b11, 32'h0F);
        rd("clr_mscratch", 12'h340, 32'hF0);
        csr_wr(12'h340, 2'b10, 32'h100);
        rd("set_mscratch", 12'h340, 32'h1F0);
        csr_wr(12'h7C0, 2'b01, 32'hDEAD);
        rd("unmapped", 12'h7C0, 32'h0);
        csr_wr(12'h341, 2'b01, 32'h3003);
        rd("warl_mepc", 12'h341, 32'h3000);

        // trap uses the rewritten mtvec; reset lands mid-flush
        ev(1'b1, 1'b0, 4'd3, 32'h5000, 32'h0);
        check("newvec_target", bus.o_redirectPC, 32'h1234);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_flush", 32'(bus.o_flush), 32'h0);
        check("midrst_redirect", 32'(bus.o_redirect), 32'h0);
        check("midrst_rpc", bus.o_redirectPC, 32'h0);
        check("midrst_priv", 32'(bus.o_nowPrivMode), 32'h3);
        rd("midrst_mtvec", 12'h305, 32'h0000_1000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        rd("post_rst_mepc", 12'h341, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
